// File: rtl/lc3_control_pkg.sv
// Shared types and encodings for the LC3 multicycle control sequencer.
package lc3_control_pkg;

  typedef enum logic [3:0] {
    RST       = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    EXECUTE   = 4'd3,
    READ_IND  = 4'd4,
    READ_MEM  = 4'd5,
    WRITE_MEM = 4'd6,
    WRITEBACK = 4'd7,
    UPDATE_PC = 4'd8
  } state_e;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam logic [1:0] MEM_READ     = 2'b00;
  localparam logic [1:0] MEM_READ_IND = 2'b01;
  localparam logic [1:0] MEM_WRITE    = 2'b10;
  localparam logic [1:0] MEM_IDLE     = 2'b11;

  function automatic logic is_mem_state(input state_e s);
    return (s == READ_IND) || (s == READ_MEM) || (s == WRITE_MEM);
  endfunction

endpackage

// File: rtl/lc3_mem_timer.sv
// Counts cycles spent in a memory state and flags an access that never completes.
module lc3_mem_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic done,
  output logic timeout
);

  localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Next count: restart on state change, otherwise advance while in a memory state.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 8'd0;
    end else if (enable && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // A completing access in the final cycle is never reported as a timeout.
  assign timeout = enable && !done && (count_q == LIMIT);

endmodule

// File: rtl/lc3_controller.sv
// LC3 multicycle control sequencer: phase enables, memory mode and branch decision.
module lc3_controller
  import lc3_control_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        complete_instr,
  input  logic        complete_data,
  input  logic [15:0] IR_Exec,
  input  logic [2:0]  NZP,
  input  logic [2:0]  psr,
  output logic        enable_fetch,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        enable_updatePC,
  output logic        br_taken,
  output logic [1:0]  mem_state,
  output logic        mem_error
);

  state_e     state_q, state_d;
  logic [3:0] opcode;
  logic       timeout;
  logic       timer_clear;
  logic       timer_enable;
  logic       unused_ir_bits;

  logic       enable_fetch_q, enable_fetch_d;
  logic       enable_decode_q, enable_decode_d;
  logic       enable_execute_q, enable_execute_d;
  logic       enable_writeback_q, enable_writeback_d;
  logic       enable_updatePC_q, enable_updatePC_d;
  logic       br_taken_q, br_taken_d;
  logic [1:0] mem_state_q, mem_state_d;
  logic       mem_error_q, mem_error_d;

  assign opcode         = IR_Exec[15:12];
  assign unused_ir_bits = ^IR_Exec[11:0];

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RST:     state_d = FETCH;
      FETCH:   state_d = complete_instr ? DECODE : FETCH;
      DECODE:  state_d = EXECUTE;
      EXECUTE: begin
        case (opcode)
          OP_ADD, OP_AND, OP_NOT, OP_LEA: state_d = WRITEBACK;
          OP_LD, OP_LDR:                  state_d = READ_MEM;
          OP_LDI, OP_STI:                 state_d = READ_IND;
          OP_ST, OP_STR:                  state_d = WRITE_MEM;
          default:                        state_d = UPDATE_PC;
        endcase
      end
      READ_IND: begin
        if (complete_data) begin
          state_d = (opcode == OP_LDI) ? READ_MEM : WRITE_MEM;
        end else if (timeout) begin
          state_d = UPDATE_PC;
        end else begin
          state_d = READ_IND;
        end
      end
      READ_MEM: begin
        if (complete_data) begin
          state_d = WRITEBACK;
        end else if (timeout) begin
          state_d = UPDATE_PC;
        end else begin
          state_d = READ_MEM;
        end
      end
      WRITE_MEM: begin
        if (complete_data || timeout) begin
          state_d = UPDATE_PC;
        end else begin
          state_d = WRITE_MEM;
        end
      end
      WRITEBACK: state_d = UPDATE_PC;
      UPDATE_PC: state_d = FETCH;
      default:   state_d = RST;
    endcase
  end

  // Any state change restarts the timer, so every memory state is entered with a zero count.
  assign timer_clear  = (state_d != state_q);
  assign timer_enable = is_mem_state(state_q);

  lc3_mem_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .done    (complete_data),
    .timeout (timeout)
  );

  // Output values for the state being entered, so outputs line up with state_q.
  always_comb begin
    enable_fetch_d     = (state_d == FETCH);
    enable_decode_d    = (state_d == DECODE);
    enable_execute_d   = (state_d == EXECUTE);
    enable_writeback_d = (state_d == WRITEBACK);
    enable_updatePC_d  = (state_d == UPDATE_PC);
    mem_error_d        = mem_error_q | (timer_enable & timeout);
    case (state_d)
      READ_IND:  mem_state_d = MEM_READ_IND;
      READ_MEM:  mem_state_d = MEM_READ;
      WRITE_MEM: mem_state_d = MEM_WRITE;
      default:   mem_state_d = MEM_IDLE;
    endcase
    br_taken_d = 1'b0;
    if (state_d == UPDATE_PC) begin
      case (opcode)
        OP_JMP:  br_taken_d = 1'b1;
        OP_BR:   br_taken_d = |(NZP & psr);
        default: br_taken_d = 1'b0;
      endcase
    end else begin
      br_taken_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q            <= RST;
      enable_fetch_q     <= 1'b0;
      enable_decode_q    <= 1'b0;
      enable_execute_q   <= 1'b0;
      enable_writeback_q <= 1'b0;
      enable_updatePC_q  <= 1'b0;
      br_taken_q         <= 1'b0;
      mem_state_q        <= MEM_IDLE;
      mem_error_q        <= 1'b0;
    end else begin
      state_q            <= state_d;
      enable_fetch_q     <= enable_fetch_d;
      enable_decode_q    <= enable_decode_d;
      enable_execute_q   <= enable_execute_d;
      enable_writeback_q <= enable_writeback_d;
      enable_updatePC_q  <= enable_updatePC_d;
      br_taken_q         <= br_taken_d;
      mem_state_q        <= mem_state_d;
      mem_error_q        <= mem_error_d;
    end
  end

  assign enable_fetch     = enable_fetch_q;
  assign enable_decode    = enable_decode_q;
  assign enable_execute   = enable_execute_q;
  assign enable_writeback = enable_writeback_q;
  assign enable_updatePC  = enable_updatePC_q;
  assign br_taken         = br_taken_q;
  assign mem_state        = mem_state_q;
  assign mem_error        = mem_error_q;

endmodule

// File: tb/tb_lc3_controller.sv
// Directed, table-driven bench for lc3_controller; each instruction is traced as a phase string.
module tb_lc3_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        complete_instr;
  logic        complete_data;
  logic [15:0] IR_Exec;
  logic [2:0]  NZP;
  logic [2:0]  psr;
  logic        enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC;
  logic        br_taken;
  logic [1:0]  mem_state;
  logic        mem_error;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  lc3_controller #(.MEM_TIMEOUT(8)) dut (
    .clock            (clock),
    .reset            (reset),
    .complete_instr   (complete_instr),
    .complete_data    (complete_data),
    .IR_Exec          (IR_Exec),
    .NZP              (NZP),
    .psr              (psr),
    .enable_fetch     (enable_fetch),
    .enable_decode    (enable_decode),
    .enable_execute   (enable_execute),
    .enable_writeback (enable_writeback),
    .enable_updatePC  (enable_updatePC),
    .br_taken         (br_taken),
    .mem_state        (mem_state),
    .mem_error        (mem_error)
  );

  // fw: FETCH cycles with complete_instr=0; mw: wait cycles before complete_data (255 = never)
  typedef struct {
    string       name;
    logic [15:0] ir;
    logic [2:0]  nzp;
    logic [2:0]  psr;
    int          fw;
    int          mw;
    string       trace;
    logic        br;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic [15:0] ir, input logic [2:0] nzp,
                     input logic [2:0] p, input int fw, input int mw, input string trace,
                     input logic br, input logic err);
    vec_t v;
    v.name = name; v.ir = ir; v.nzp = nzp; v.psr = p; v.fw = fw; v.mw = mw;
    v.trace = trace; v.br = br; v.err = err;
    vecs.push_back(v);
  endtask

  // One letter per cycle: F D E W U for the enables, I R S for memory modes, - for idle.
  function automatic byte code_of();
    logic [4:0] en;
    en = {enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC};
    if (en != 5'b00000) begin
      if (mem_state != 2'b11) return "?";
      case (en)
        5'b10000: return "F";
        5'b01000: return "D";
        5'b00100: return "E";
        5'b00010: return "W";
        5'b00001: return "U";
        default:  return "?";
      endcase
    end
    case (mem_state)
      2'b00:   return "R";
      2'b01:   return "I";
      2'b10:   return "S";
      default: return "-";
    endcase
  endfunction

  task automatic chk_str(input string name, input string got, input string exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %s expected %s", name, got, exp);
    end
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic run_instr(input vec_t v, output string tr, output logic br, output logic err);
    int  fcnt;
    int  mcnt;
    byte c;
    byte prev;
    bit  fin;
    tr = ""; fcnt = 0; mcnt = 0; prev = " "; br = 1'b0; err = 1'b0; fin = 1'b0;
    IR_Exec = v.ir; NZP = v.nzp; psr = v.psr;
    for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
      @(negedge clock);
      c = code_of();
      mcnt = (c == prev) ? mcnt + 1 : 1;
      prev = c;
      if (c == "F") fcnt++;
      complete_instr = (c == "F") && (fcnt > v.fw);
      complete_data  = (c == "R" || c == "I" || c == "S") && (mcnt == v.mw + 1);
      if (!(c == "-" && tr.len() == 0)) tr = $sformatf("%s%c", tr, c);
      if (c == "U") begin
        br  = br_taken;
        err = mem_error;
        fin = 1'b1;
      end
    end
    if (!fin) $display("FAIL %s_bound: no UPDATE_PC within 60 cycles", v.name);
    complete_instr = 1'b0;
    complete_data  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    string tr;
    logic  br;
    logic  err;
    run_instr(v, tr, br, err);
    chk_str({v.name, "_trace"}, tr, v.trace);
    chk({v.name, "_br"}, {7'd0, br}, {7'd0, v.br});
    chk({v.name, "_err"}, {7'd0, err}, {7'd0, v.err});
  endtask

  initial begin
    vec_t v;
    bit   found;
    reset = 1'b0; complete_instr = 1'b0; complete_data = 1'b0;
    IR_Exec = 16'h0000; NZP = 3'b000; psr = 3'b000;

    add("add",      16'h1042, 3'b000, 3'b000, 0, 0,   "FDEWU",         1'b0, 1'b0);
    add("and",      16'h5042, 3'b000, 3'b000, 0, 0,   "FDEWU",         1'b0, 1'b0);
    add("not",      16'h907F, 3'b000, 3'b000, 0, 0,   "FDEWU",         1'b0, 1'b0);
    add("lea",      16'hEA05, 3'b000, 3'b000, 0, 0,   "FDEWU",         1'b0, 1'b0);
    add("ld",       16'h2201, 3'b000, 3'b000, 0, 0,   "FDERWU",        1'b0, 1'b0);
    add("ldr_w3",   16'h6201, 3'b000, 3'b000, 0, 3,   "FDERRRRWU",     1'b0, 1'b0);
    add("ldi",      16'hA201, 3'b000, 3'b000, 0, 0,   "FDEIRWU",       1'b0, 1'b0);
    add("ldi_w2",   16'hA201, 3'b000, 3'b000, 0, 2,   "FDEIIIRRRWU",   1'b0, 1'b0);
    add("st",       16'h3205, 3'b000, 3'b000, 0, 0,   "FDESU",         1'b0, 1'b0);
    add("sti",      16'hB201, 3'b000, 3'b000, 0, 0,   "FDEISU",        1'b0, 1'b0);
    add("str_w1",   16'h7205, 3'b000, 3'b000, 0, 1,   "FDESSU",        1'b0, 1'b0);
    add("brz_t",    16'h0401, 3'b010, 3'b010, 0, 0,   "FDEU",          1'b1, 1'b0);
    add("brz_nt",   16'h0401, 3'b010, 3'b100, 0, 0,   "FDEU",          1'b0, 1'b0);
    add("brnzp",    16'h0E00, 3'b111, 3'b001, 0, 0,   "FDEU",          1'b1, 1'b0);
    add("jmp",      16'hC1C0, 3'b000, 3'b000, 0, 0,   "FDEU",          1'b1, 1'b0);
    add("nop",      16'hD000, 3'b111, 3'b111, 0, 0,   "FDEU",          1'b0, 1'b0);
    add("fetch_w4", 16'h1042, 3'b000, 3'b000, 4, 0,   "FFFFFDEWU",     1'b0, 1'b0);
    add("ld_last",  16'h2201, 3'b000, 3'b000, 0, 7,   "FDERRRRRRRRWU", 1'b0, 1'b0);
    add("st_tmo",   16'h3205, 3'b000, 3'b000, 0, 255, "FDESSSSSSSSU",  1'b0, 1'b1);
    add("add_stk",  16'h1042, 3'b000, 3'b000, 0, 0,   "FDEWU",         1'b0, 1'b1);
    add("ldi_tmo",  16'hA201, 3'b000, 3'b000, 0, 255, "FDEIIIIIIIIU",  1'b0, 1'b1);

    #12;
    chk("rst_enables", {3'd0, enable_fetch, enable_decode, enable_execute, enable_writeback,
        enable_updatePC}, 8'h00);
    chk("rst_mem_state", {6'd0, mem_state}, 8'h03);
    chk("rst_mem_error", {7'd0, mem_error}, 8'h00);
    chk("rst_br", {7'd0, br_taken}, 8'h00);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // Asynchronous reset in the middle of a read access.
    IR_Exec = 16'h2201; NZP = 3'b000; psr = 3'b000;
    found = 1'b0;
    for (int cyc = 0; cyc < 20 && !found; cyc++) begin
      @(negedge clock);
      complete_instr = 1'b1;
      complete_data  = 1'b0;
      if (mem_state == 2'b00) found = 1'b1;
    end
    chk("reach_read_mem", {7'd0, found}, 8'h01);
    chk("pre_reset_err", {7'd0, mem_error}, 8'h01);
    #2 reset = 1'b0;
    #1;
    chk("async_mem_state", {6'd0, mem_state}, 8'h03);
    chk("async_mem_error", {7'd0, mem_error}, 8'h00);
    chk("async_enables", {3'd0, enable_fetch, enable_decode, enable_execute, enable_writeback,
        enable_updatePC}, 8'h00);
    complete_instr = 1'b0;
    @(negedge clock);
    chk_str("hold_rst", string'(code_of()), "-");
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk_str("post_rst_cycle", string'(code_of()), "-");
    @(negedge clock);
    chk_str("post_rst_fetch", string'(code_of()), "F");
    v = vecs[0];
    v.name = "add_after_rst";
    run_vec(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
